// File: rtl/seg_scanner.sv
// Eight-digit common-anode scanner for the washer's time and water figures.
// Each 6-bit figure is shown as two decimal digits; figures are latched once per frame.
module seg_scanner #(
   parameter int SCA_CMAX = 100000,
   parameter int GAP      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] u_tot,
   input  logic [5:0] u_cur,
   input  logic [5:0] u_wat,
   input  logic       fl_disp,
   input  logic       clk_fl,
   output logic [7:0] seg_n,
   output logic [7:0] an_n
);

   localparam int CW = (SCA_CMAX > 1) ? $clog2(SCA_CMAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCA_CMAX - 1);
   localparam logic [CW-1:0] GAP_C    = CW'(GAP);

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic          fl_blank;
   logic [5:0]    s_tot;
   logic [5:0]    s_cur;
   logic [5:0]    s_wat;
   logic          slot_end;
   logic [6:0]    bcd_tot;
   logic [6:0]    bcd_cur;
   logic [6:0]    bcd_wat;
   logic [3:0]    digit;
   logic          blank;
   logic [7:0]    code;

   // Returns {tens[2:0], units[3:0]} for 0..63.
   function automatic logic [6:0] to_bcd(input logic [5:0] v);
      logic [2:0] t;
      logic [5:0] r;
      if (v >= 6'd60)      begin t = 3'd6; r = v - 6'd60; end
      else if (v >= 6'd50) begin t = 3'd5; r = v - 6'd50; end
      else if (v >= 6'd40) begin t = 3'd4; r = v - 6'd40; end
      else if (v >= 6'd30) begin t = 3'd3; r = v - 6'd30; end
      else if (v >= 6'd20) begin t = 3'd2; r = v - 6'd20; end
      else if (v >= 6'd10) begin t = 3'd1; r = v - 6'd10; end
      else                 begin t = 3'd0; r = v;          end
      return {t, r[3:0]};
   endfunction

   function automatic logic [7:0] seg_lut(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   assign slot_end = (cnt == CNT_LAST);
   assign bcd_tot  = to_bcd(s_tot);
   assign bcd_cur  = to_bcd(s_cur);
   assign bcd_wat  = to_bcd(s_wat);

   // Digit map; tens positions blank below 10, the u_cur pair blanks while flashing.
   always_comb begin
      digit = 4'd0;
      blank = 1'b1;
      case (idx)
         3'd0: begin digit = bcd_wat[3:0];         blank = 1'b0;                   end
         3'd1: begin digit = {1'b0, bcd_wat[6:4]}; blank = (s_wat < 6'd10);       end
         3'd3: begin digit = bcd_cur[3:0];         blank = fl_blank;               end
         3'd4: begin digit = {1'b0, bcd_cur[6:4]}; blank = (s_cur < 6'd10) || fl_blank; end
         3'd6: begin digit = bcd_tot[3:0];         blank = 1'b0;                   end
         3'd7: begin digit = {1'b0, bcd_tot[6:4]}; blank = (s_tot < 6'd10);       end
         default: ;
      endcase
      code = blank ? 8'hFF : seg_lut(digit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         idx      <= 3'd0;
         fl_blank <= 1'b0;
         s_tot    <= u_tot;
         s_cur    <= u_cur;
         s_wat    <= u_wat;
         an_n     <= 8'hFF;
         seg_n    <= 8'hFF;
      end else begin
         if (slot_end) begin
            cnt      <= '0;
            idx      <= idx + 3'd1;
            fl_blank <= fl_disp && !clk_fl;
         end else begin
            cnt <= cnt + 1'b1;
         end
         // Load at the very end of digit 7 so a frame never mixes old and new figures.
         if (slot_end && idx == 3'd7) begin
            s_tot <= u_tot;
            s_cur <= u_cur;
            s_wat <= u_wat;
         end
         if (cnt < GAP_C) begin
            an_n  <= 8'hFF;
            seg_n <= 8'hFF;
         end else begin
            an_n  <= ~(8'd1 << idx);
            seg_n <= code;
         end
      end
   end

endmodule

// File: tb/tb_seg_scanner.sv
// Directed bench for seg_scanner with a short slot (SCA_CMAX=4, GAP=1).
// k counts clock edges since reset release; output after edge k shows state (k-1).
module tb_seg_scanner;

   localparam int SCA = 4;
   localparam int GP  = 1;
   localparam int FRAME = 8 * SCA;

   logic       clk;
   logic       rst;
   logic [5:0] u_tot;
   logic [5:0] u_cur;
   logic [5:0] u_wat;
   logic       fl_disp;
   logic       clk_fl;
   logic [7:0] seg_n;
   logic [7:0] an_n;

   int n_tests;
   int n_fail;
   int k;
   logic [7:0] exp_seg [8];

   seg_scanner #(.SCA_CMAX(SCA), .GAP(GP)) dut (
      .clk(clk), .rst(rst), .u_tot(u_tot), .u_cur(u_cur), .u_wat(u_wat),
      .fl_disp(fl_disp), .clk_fl(clk_fl), .seg_n(seg_n), .an_n(an_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic align_frame();
      while (k % FRAME != 0) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; u_tot = 6'd45; u_cur = 6'd7; u_wat = 6'd63;
      fl_disp = 1'b0; clk_fl = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (an_n !== 8'hFF || seg_n !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_hold an_n=%h seg_n=%h expected FF/FF", an_n, seg_n);
         end
      end
      rst = 1'b0; k = 0;
      tick();
      n_tests++;
      if (an_n !== 8'hFF || seg_n !== 8'hFF) begin
         n_fail++;
         $display("FAIL release_gap an_n=%h seg_n=%h expected FF/FF", an_n, seg_n);
      end
      tick();
      n_tests++;
      if (an_n !== 8'hFE || seg_n !== 8'hB0) begin
         n_fail++;
         $display("FAIL first_digit an_n=%h seg_n=%h expected FE/B0", an_n, seg_n);
      end
   endtask

   task automatic test_full_frame();
      int ph, sl;
      logic [7:0] ea, es;
      exp_seg = '{8'hB0, 8'h82, 8'hFF, 8'hF8, 8'hFF, 8'hFF, 8'h92, 8'h99};
      align_frame();
      for (int c = 0; c < FRAME; c++) begin
         tick();
         ph = (k - 1) % SCA; sl = ((k - 1) / SCA) % 8;
         ea = (ph < GP) ? 8'hFF : ~(8'd1 << sl);
         es = (ph < GP) ? 8'hFF : exp_seg[sl];
         n_tests++;
         if (an_n !== ea || seg_n !== es) begin
            n_fail++;
            $display("FAIL full_frame slot=%0d ph=%0d an_n=%h seg_n=%h expected %h/%h", sl, ph, an_n, seg_n, ea, es);
         end
      end
   endtask

   task automatic test_mid_frame_change();
      int ph, sl;
      logic [7:0] ea, es;
      align_frame();
      for (int c = 0; c < 2 * FRAME; c++) begin
         tick();
         ph = (k - 1) % SCA; sl = ((k - 1) / SCA) % 8;
         if (c < FRAME) exp_seg = '{8'hB0, 8'h82, 8'hFF, 8'hF8, 8'hFF, 8'hFF, 8'h92, 8'h99};
         else           exp_seg = '{8'hB0, 8'h82, 8'hFF, 8'hF8, 8'hFF, 8'hFF, 8'hA4, 8'hF9};
         ea = (ph < GP) ? 8'hFF : ~(8'd1 << sl);
         es = (ph < GP) ? 8'hFF : exp_seg[sl];
         n_tests++;
         if (an_n !== ea || seg_n !== es) begin
            n_fail++;
            $display("FAIL mid_change frame=%0d slot=%0d an_n=%h seg_n=%h expected %h/%h", c / FRAME, sl, an_n, seg_n, ea, es);
         end
         if (c < FRAME && sl == 3 && ph == 1) u_tot = 6'd12;
      end
   endtask

   task automatic test_flash();
      int ph, sl;
      logic [7:0] ea, es;
      align_frame();
      fl_disp = 1'b1; clk_fl = 1'b0;
      for (int c = 0; c < 2 * FRAME; c++) begin
         if (c == FRAME) clk_fl = 1'b1;
         tick();
         ph = (k - 1) % SCA; sl = ((k - 1) / SCA) % 8;
         if (c < FRAME) exp_seg = '{8'hB0, 8'h82, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA4, 8'hF9};
         else           exp_seg = '{8'hB0, 8'h82, 8'hFF, 8'hF8, 8'hFF, 8'hFF, 8'hA4, 8'hF9};
         ea = (ph < GP) ? 8'hFF : ~(8'd1 << sl);
         es = (ph < GP) ? 8'hFF : exp_seg[sl];
         n_tests++;
         if (an_n !== ea || seg_n !== es) begin
            n_fail++;
            $display("FAIL flash clk_fl=%0b slot=%0d an_n=%h seg_n=%h expected %h/%h", clk_fl, sl, an_n, seg_n, ea, es);
         end
      end
      fl_disp = 1'b0; clk_fl = 1'b0;
   endtask

   task automatic test_boundary();
      int ph, sl;
      logic [7:0] ea, es;
      align_frame();
      u_cur = 6'd0; u_wat = 6'd10; u_tot = 6'd9;
      for (int c = 0; c < FRAME; c++) tick();
      exp_seg = '{8'hC0, 8'hF9, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'h90, 8'hFF};
      for (int c = 0; c < FRAME; c++) begin
         tick();
         ph = (k - 1) % SCA; sl = ((k - 1) / SCA) % 8;
         ea = (ph < GP) ? 8'hFF : ~(8'd1 << sl);
         es = (ph < GP) ? 8'hFF : exp_seg[sl];
         n_tests++;
         if (an_n !== ea || seg_n !== es) begin
            n_fail++;
            $display("FAIL boundary slot=%0d ph=%0d an_n=%h seg_n=%h expected %h/%h", sl, ph, an_n, seg_n, ea, es);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      int ph, sl;
      logic [7:0] ea, es;
      align_frame();
      for (int c = 0; c < 5 * SCA + 2; c++) tick();
      n_tests++;
      if (an_n !== 8'hDF) begin
         n_fail++;
         $display("FAIL pre_reset_slot5 an_n=%h expected DF", an_n);
      end
      u_tot = 6'd33; u_cur = 6'd50; u_wat = 6'd5;
      rst = 1'b1;
      tick();
      n_tests++;
      if (an_n !== 8'hFF || seg_n !== 8'hFF) begin
         n_fail++;
         $display("FAIL mid_reset an_n=%h seg_n=%h expected FF/FF", an_n, seg_n);
      end
      rst = 1'b0; k = 0;
      u_tot = 6'd0; u_cur = 6'd0; u_wat = 6'd0;
      exp_seg = '{8'h92, 8'hFF, 8'hFF, 8'hC0, 8'h92, 8'hFF, 8'hB0, 8'hB0};
      for (int c = 0; c < FRAME; c++) begin
         tick();
         ph = (k - 1) % SCA; sl = ((k - 1) / SCA) % 8;
         ea = (ph < GP) ? 8'hFF : ~(8'd1 << sl);
         es = (ph < GP) ? 8'hFF : exp_seg[sl];
         n_tests++;
         if (an_n !== ea || seg_n !== es) begin
            n_fail++;
            $display("FAIL restart slot=%0d ph=%0d an_n=%h seg_n=%h expected %h/%h", sl, ph, an_n, seg_n, ea, es);
         end
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0; k = 0;
      test_reset();
      test_full_frame();
      test_mid_frame_change();
      test_flash();
      test_boundary();
      test_reset_mid_scan();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scanner.md
Name: seg_scanner

Overview:
- Consumer stage for the washer's time and water figures (u_tot, u_cur, u_wat), the current-stage flash request (fl_disp) and the shared flash clock (clk_fl).
- Multiplexes the figures onto an 8-digit common-anode seven-segment bank.
- Converts each 6-bit value to two decimal digits, with leading-zero blanking and a blank guard gap between digits.
- Latches all figures once per frame, so one frame never shows mixed old and new values.

Parameters:
SCA_CMAX, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range > GAP
GAP, 2, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0..SCA_CMAX-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
u_tot  in  6  total remaining time units, 0..63
u_cur  in  6  current-stage remaining units, 0..63
u_wat  in  6  water level units, 0..63
fl_disp  in  1  flash request for the u_cur digits
clk_fl  in  1  flash phase level (generated in the clk domain)
seg_n  out  8  {dp,g,f,e,d,c,b,a}, active-low, registered
an_n  out  8  digit enables, active-low, bit i = digit i, registered

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Every flop is reset on the clk edge where rst=1.
- Reset values:
  - an_n=8'hFF, seg_n=8'hFF.
  - Slot index idx=0, slot counter cnt=0.
  - Flash latch fl_blank=0.
  - Snapshot registers load u_tot/u_cur/u_wat on every reset cycle.
- Slot counter:
  - cnt runs 0..SCA_CMAX-1.
  - At cnt==SCA_CMAX-1: cnt<=0 and idx<=idx+1, wrapping 7->0.
- Snapshot: s_tot/s_cur/s_wat load the inputs on the cycle where idx==7 and cnt==SCA_CMAX-1, so new values take effect from digit 0 of the next frame. Input changes at any other time are ignored until the next frame.
- Flash latch: on each cycle with cnt==SCA_CMAX-1, fl_blank <= fl_disp && !clk_fl. It is therefore constant for a whole slot.
- Digit map:
  - idx0 = s_wat units, idx1 = s_wat tens.
  - idx2 = blank.
  - idx3 = s_cur units, idx4 = s_cur tens.
  - idx5 = blank.
  - idx6 = s_tot units, idx7 = s_tot tens.
- Decimal conversion: tens = v/10 (0..6), units = v%10. Combinational on the snapshot, 6-bit in, 3+4 bits out.
- Leading-zero blanking:
  - A tens digit shows blank when v<10.
  - A units digit always shows, including 0.
- Flash: when fl_blank=1, idx3 and idx4 show blank. Other digits are unaffected.
- Segment codes (dp always off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - blank=FF.
- Output timing: an_n and seg_n are registered from the current idx/cnt state, one cycle behind it.
  - Guard gap (cnt<GAP): an_n=FF, seg_n=FF on the following cycle.
  - Otherwise: an_n = ~(1<<idx) and seg_n = code(idx).
  - With GAP=0 a digit is enabled for the full slot.
- Reset mid-scan: outputs return to FF/FF on the next cycle and scanning restarts at idx0 with freshly captured inputs.
- Frame period = 8*SCA_CMAX cycles. The first anode goes low at output cycle GAP+1 after rst falls.

Test Plan:
1. Reset release: use SCA_CMAX=4, GAP=1, u_tot=45, u_cur=7, u_wat=63, fl_disp=0.
   - Required while rst is high: an_n=FF, seg_n=FF.
   - Required after rst falls: an_n=FE with seg_n=B0 first appears 2 cycles later.
2. Full frame, same values. Per slot, the digit-enabled value must be:
   - idx0 B0, idx1 82, idx2 FF, idx3 F8, idx4 FF.
   - idx5 FF, idx6 92, idx7 99.
   - Each slot is preceded by exactly 1 cycle of an_n=FF.
3. Mid-frame change: set u_tot=12 while idx=3.
   - Required: idx6/idx7 still show 92/99 this frame.
   - Required next frame: idx6=A4, idx7=F9.
4. Flash: fl_disp=1 with clk_fl=0 held across a slot boundary.
   - Required: idx3/idx4 seg_n=FF while their anodes are low.
   - With clk_fl=1: normal F8 at idx3.
   - Other digits unchanged.
5. Boundary values: u_cur=0, u_wat=10, u_tot=9.
   - Required: idx3=C0, idx4=FF, idx0=C0, idx1=F9, idx6=90, idx7=FF.
6. Reset mid-scan: assert rst for 1 cycle at idx=5.
   - Required: next cycle an_n=FF, seg_n=FF.
   - Required: scanning resumes at idx0 with the inputs current at reset, and no slot-5 continuation.
